// File: rtl/piece_queue_pkg.sv
// ============================================================================
// piece_queue_pkg : shared tetromino encoding, piece type and LFSR helpers
// Rev 1.0
// ============================================================================
`default_nettype none

package piece_queue_pkg;

    localparam int PIECE_KINDS = 7;

    typedef logic [2:0] piece_idx_t;

    // Encoding 0..6 = I,O,T,S,Z,J,L
    localparam piece_idx_t TETROMINO_EMPTY = 3'd7;
    localparam logic [6:0] BAG_FULL        = 7'h7F;

    // Right-shifting Fibonacci form of taps 16,14,13,11
    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        logic fb;
        fb = l[0] ^ l[2] ^ l[3] ^ l[5];
        return {fb, l[15:1]};
    endfunction

    function automatic piece_idx_t lfsr_candidate(input logic [15:0] l);
        return (l[2:0] == 3'd7) ? 3'd0 : l[2:0];
    endfunction

endpackage

`default_nettype wire

// File: rtl/piece_queue_bag_picker.sv
// ============================================================================
// bag_picker : first set bag bit at or above the candidate, wrapping at 7
// Rev 1.0
// ============================================================================
`default_nettype none

module bag_picker
    import piece_queue_pkg::*;
(
    input  logic [6:0] bag_mask_i,
    input  piece_idx_t cand_i,
    output piece_idx_t pick_o,
    output logic [6:0] mask_next_o
);

    logic [7:0] mask_ext;
    logic [3:0] pos;
    logic       found;
    logic [6:0] cleared;

    always_comb begin
        mask_ext = {1'b0, bag_mask_i};
        pos      = 4'd0;
        found    = 1'b0;
        pick_o   = cand_i;
        for (int k = 0; k < PIECE_KINDS; k++) begin
            pos = {1'b0, cand_i} + 4'(k);
            if (pos >= 4'd7) begin
                pos = pos - 4'd7;
            end
            if (!found && mask_ext[pos[2:0]]) begin
                pick_o = pos[2:0];
                found  = 1'b1;
            end
        end
        cleared     = bag_mask_i & ~(7'b1 << pick_o);
        // An exhausted bag refills on the same edge that takes its last piece
        mask_next_o = (cleared == 7'h00) ? BAG_FULL : cleared;
    end

endmodule

`default_nettype wire

// File: rtl/piece_queue.sv
// ============================================================================
// piece_queue : 7-bag / random piece source, preview FIFO and hold slot
// Rev 1.0
// ============================================================================
`default_nettype none

module piece_queue
    import piece_queue_pkg::*;
#(
    parameter int          PREVIEW_DEPTH = 3,
    parameter int          RANDOM_MODE   = 0,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       spawn_req_i,
    input  logic                       hold_req_i,
    input  logic [2:0]                 cur_idx_i,
    input  logic                       lock_done_i,
    output logic                       spawn_valid_o,
    output logic [2:0]                 spawn_idx_o,
    output logic                       spawn_from_hold_o,
    output logic                       hold_reject_o,
    output logic [PREVIEW_DEPTH*3-1:0] preview_idx_o,
    output logic [2:0]                 hold_idx_o,
    output logic                       hold_used_o,
    output logic [15:0]                pieces_dealt_o
);

    localparam logic [15:0] SEED  = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
    localparam logic [2:0]  DEPTH = 3'(PREVIEW_DEPTH);

    logic [15:0] lfsr_q, lfsr_d;
    logic [6:0]  bag_q, bag_d;
    logic [2:0]  count_q, count_d;
    piece_idx_t  fifo_q [PREVIEW_DEPTH];
    piece_idx_t  fifo_d [PREVIEW_DEPTH];
    logic        pending_q, pending_d;
    piece_idx_t  hold_q, hold_d;
    logic        hold_used_q, hold_used_d;
    logic        spawn_valid_q, spawn_valid_d;
    piece_idx_t  spawn_idx_q, spawn_idx_d;
    logic        from_hold_q, from_hold_d;
    logic        reject_q, reject_d;
    logic [15:0] dealt_q, dealt_d;

    piece_idx_t  cand;
    piece_idx_t  push_piece;
    logic [6:0]  bag_next;
    logic        can_pop;
    logic        pop;
    logic        push;
    logic [2:0]  wr_idx;

    assign cand = lfsr_candidate(lfsr_q);

    if (RANDOM_MODE != 0) begin : g_random
        assign push_piece = cand;
        assign bag_next   = bag_q;
    end else begin : g_bag
        bag_picker u_bag_picker (
            .bag_mask_i  (bag_q),
            .cand_i      (cand),
            .pick_o      (push_piece),
            .mask_next_o (bag_next)
        );
    end

    always_comb begin
        can_pop       = (count_q != 3'd0);
        pop           = 1'b0;
        pending_d     = pending_q;
        hold_d        = hold_q;
        hold_used_d   = lock_done_i ? 1'b0 : hold_used_q;
        spawn_valid_d = 1'b0;
        spawn_idx_d   = spawn_idx_q;
        from_hold_d   = 1'b0;
        reject_d      = 1'b0;

        // While a spawn is pending, further spawn requests are absorbed
        if (pending_q) begin
            if (can_pop) begin
                pop       = 1'b1;
                pending_d = 1'b0;
            end
        end else if (spawn_req_i) begin
            if (can_pop) begin
                pop = 1'b1;
            end else begin
                pending_d = 1'b1;
            end
        end

        if (hold_req_i) begin
            if (spawn_req_i || hold_used_q || pending_q) begin
                reject_d = 1'b1;
            end else if (hold_q == TETROMINO_EMPTY) begin
                hold_d      = cur_idx_i;
                hold_used_d = 1'b1;
                if (can_pop) begin
                    pop = 1'b1;
                end else begin
                    pending_d = 1'b1;
                end
            end else begin
                spawn_valid_d = 1'b1;
                spawn_idx_d   = hold_q;
                from_hold_d   = 1'b1;
                hold_d        = cur_idx_i;
                hold_used_d   = 1'b1;
            end
        end

        if (pop) begin
            spawn_valid_d = 1'b1;
            spawn_idx_d   = fifo_q[0];
            from_hold_d   = 1'b0;
        end

        // Pushing alongside a pop keeps a full preview full
        push   = (count_q < DEPTH) || pop;
        wr_idx = count_q - {2'b00, pop};

        for (int i = 0; i < PREVIEW_DEPTH; i++) begin
            fifo_d[i] = fifo_q[i];
        end
        if (pop) begin
            for (int i = 0; i < PREVIEW_DEPTH - 1; i++) begin
                fifo_d[i] = fifo_q[i+1];
            end
            fifo_d[PREVIEW_DEPTH-1] = TETROMINO_EMPTY;
        end
        for (int i = 0; i < PREVIEW_DEPTH; i++) begin
            if (push && (wr_idx == 3'(i))) begin
                fifo_d[i] = push_piece;
            end
        end

        count_d = count_q - {2'b00, pop} + {2'b00, push};
        dealt_d = (pop && (dealt_q != 16'hFFFF)) ? dealt_q + 16'd1 : dealt_q;
        lfsr_d  = lfsr_step(lfsr_q);
        bag_d   = push ? bag_next : bag_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q        <= SEED;
            bag_q         <= BAG_FULL;
            count_q       <= 3'd0;
            pending_q     <= 1'b0;
            hold_q        <= TETROMINO_EMPTY;
            hold_used_q   <= 1'b0;
            spawn_valid_q <= 1'b0;
            spawn_idx_q   <= TETROMINO_EMPTY;
            from_hold_q   <= 1'b0;
            reject_q      <= 1'b0;
            dealt_q       <= 16'd0;
            for (int i = 0; i < PREVIEW_DEPTH; i++) begin
                fifo_q[i] <= TETROMINO_EMPTY;
            end
        end else begin
            lfsr_q        <= lfsr_d;
            bag_q         <= bag_d;
            count_q       <= count_d;
            pending_q     <= pending_d;
            hold_q        <= hold_d;
            hold_used_q   <= hold_used_d;
            spawn_valid_q <= spawn_valid_d;
            spawn_idx_q   <= spawn_idx_d;
            from_hold_q   <= from_hold_d;
            reject_q      <= reject_d;
            dealt_q       <= dealt_d;
            for (int i = 0; i < PREVIEW_DEPTH; i++) begin
                fifo_q[i] <= fifo_d[i];
            end
        end
    end

    for (genvar g = 0; g < PREVIEW_DEPTH; g++) begin : g_preview
        assign preview_idx_o[3*g +: 3] = fifo_q[g];
    end

    assign spawn_valid_o     = spawn_valid_q;
    assign spawn_idx_o       = spawn_idx_q;
    assign spawn_from_hold_o = from_hold_q;
    assign hold_reject_o     = reject_q;
    assign hold_idx_o        = hold_q;
    assign hold_used_o       = hold_used_q;
    assign pieces_dealt_o    = dealt_q;

endmodule

`default_nettype wire

// File: tb/tb_piece_queue.sv
// ============================================================================
// tb_piece_queue : directed self-checking bench for piece_queue (depth 3, bag)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_piece_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        spawn_req;
    logic        hold_req;
    logic [2:0]  cur_idx;
    logic        lock_done;
    logic        spawn_valid;
    logic [2:0]  spawn_idx;
    logic        spawn_from_hold;
    logic        hold_reject;
    logic [8:0]  preview;
    logic [2:0]  hold_idx;
    logic        hold_used;
    logic [15:0] pieces_dealt;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [8:0]  p;
    logic [6:0]  seen;

    piece_queue #(
        .PREVIEW_DEPTH (3),
        .RANDOM_MODE   (0),
        .LFSR_SEED     (16'hACE1)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .spawn_req_i       (spawn_req),
        .hold_req_i        (hold_req),
        .cur_idx_i         (cur_idx),
        .lock_done_i       (lock_done),
        .spawn_valid_o     (spawn_valid),
        .spawn_idx_o       (spawn_idx),
        .spawn_from_hold_o (spawn_from_hold),
        .hold_reject_o     (hold_reject),
        .preview_idx_o     (preview),
        .hold_idx_o        (hold_idx),
        .hold_used_o       (hold_used),
        .pieces_dealt_o    (pieces_dealt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic no_empty(input logic [8:0] v);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (v[3*i +: 3] == 3'd7) ok = 1'b0;
        end
        return ok;
    endfunction

    task automatic check_reset_state(input string pfx);
        chk({pfx, "_preview"},   16'(preview),         16'h01FF);
        chk({pfx, "_hold_idx"},  16'(hold_idx),        16'd7);
        chk({pfx, "_spawn_idx"}, 16'(spawn_idx),       16'd7);
        chk({pfx, "_valid"},     16'(spawn_valid),     16'd0);
        chk({pfx, "_from_hold"}, 16'(spawn_from_hold), 16'd0);
        chk({pfx, "_reject"},    16'(hold_reject),     16'd0);
        chk({pfx, "_used"},      16'(hold_used),       16'd0);
        chk({pfx, "_dealt"},     pieces_dealt,         16'd0);
    endtask

    initial begin
        rst       = 1'b1;
        spawn_req = 1'b0;
        hold_req  = 1'b0;
        lock_done = 1'b0;
        cur_idx   = 3'd0;
        tick();
        tick();
        check_reset_state("rst0");

        // Spawn on the first cycle out of reset: pushes 1,0,2,4 from seed ACE1
        rst       = 1'b0;
        spawn_req = 1'b1;
        tick();
        spawn_req = 1'b0;
        chk("pend_noval", 16'(spawn_valid), 16'd0);
        chk("pend_prev",  16'(preview), 16'({3'd7, 3'd7, 3'd1}));
        tick();
        chk("pend_valid", 16'(spawn_valid), 16'd1);
        chk("pend_idx",   16'(spawn_idx), 16'd1);
        chk("pend_fromh", 16'(spawn_from_hold), 16'd0);
        chk("pend_dealt", pieces_dealt, 16'd1);
        tick();
        chk("pend_pulse", 16'(spawn_valid), 16'd0);
        tick();
        chk("pend_refill", 16'(preview), 16'({3'd4, 3'd2, 3'd0}));

        // Fill from reset: 1,0,2 land over three cycles
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        tick();
        chk("fill_partial", 16'(preview), 16'({3'd7, 3'd0, 3'd1}));
        tick();
        chk("fill_full", 16'(preview), 16'({3'd2, 3'd0, 3'd1}));
        tick();
        tick();

        // Seven spawns two cycles apart deal one complete bag
        seen = 7'h00;
        for (int k = 0; k < 7; k++) begin
            p         = preview;
            spawn_req = 1'b1;
            tick();
            spawn_req = 1'b0;
            chk("bag_valid", 16'(spawn_valid), 16'd1);
            chk("bag_idx", 16'(spawn_idx), 16'(p[2:0]));
            chk("bag_prev_full", 16'(no_empty(preview)), 16'd1);
            seen = seen | (7'b1 << spawn_idx);
            tick();
            chk("bag_pulse", 16'(spawn_valid), 16'd0);
        end
        chk("bag_perm", 16'(seen), 16'h007F);
        chk("bag_dealt", pieces_dealt, 16'd7);

        // Hold into an empty slot pops the queue
        p        = preview;
        hold_req = 1'b1;
        cur_idx  = 3'd3;
        tick();
        hold_req = 1'b0;
        chk("h1_hold",   16'(hold_idx), 16'd3);
        chk("h1_valid",  16'(spawn_valid), 16'd1);
        chk("h1_idx",    16'(spawn_idx), 16'(p[2:0]));
        chk("h1_fromh",  16'(spawn_from_hold), 16'd0);
        chk("h1_used",   16'(hold_used), 16'd1);
        chk("h1_dealt",  pieces_dealt, 16'd8);
        tick();

        // Second hold before lock is rejected
        hold_req = 1'b1;
        cur_idx  = 3'd4;
        tick();
        hold_req = 1'b0;
        chk("h2_reject", 16'(hold_reject), 16'd1);
        chk("h2_valid",  16'(spawn_valid), 16'd0);
        chk("h2_hold",   16'(hold_idx), 16'd3);
        tick();
        chk("h2_pulse",  16'(hold_reject), 16'd0);

        lock_done = 1'b1;
        tick();
        lock_done = 1'b0;
        chk("lock_clear", 16'(hold_used), 16'd0);

        // Hold with a full slot swaps without popping
        p        = preview;
        hold_req = 1'b1;
        cur_idx  = 3'd5;
        tick();
        hold_req = 1'b0;
        chk("h3_idx",   16'(spawn_idx), 16'd3);
        chk("h3_fromh", 16'(spawn_from_hold), 16'd1);
        chk("h3_valid", 16'(spawn_valid), 16'd1);
        chk("h3_hold",  16'(hold_idx), 16'd5);
        chk("h3_prev",  16'(preview), 16'(p));
        chk("h3_dealt", pieces_dealt, 16'd8);

        // lock_done with hold while locked out: rejected, flag still clears
        lock_done = 1'b1;
        hold_req  = 1'b1;
        cur_idx   = 3'd6;
        tick();
        lock_done = 1'b0;
        hold_req  = 1'b0;
        chk("lh1_reject", 16'(hold_reject), 16'd1);
        chk("lh1_used",   16'(hold_used), 16'd0);
        chk("lh1_hold",   16'(hold_idx), 16'd5);

        // lock_done with an accepted hold leaves the flag set
        lock_done = 1'b1;
        hold_req  = 1'b1;
        cur_idx   = 3'd6;
        tick();
        lock_done = 1'b0;
        hold_req  = 1'b0;
        chk("lh2_reject", 16'(hold_reject), 16'd0);
        chk("lh2_idx",    16'(spawn_idx), 16'd5);
        chk("lh2_fromh",  16'(spawn_from_hold), 16'd1);
        chk("lh2_hold",   16'(hold_idx), 16'd6);
        chk("lh2_used",   16'(hold_used), 16'd1);

        // Spawn and hold together: spawn wins
        p         = preview;
        spawn_req = 1'b1;
        hold_req  = 1'b1;
        cur_idx   = 3'd2;
        tick();
        spawn_req = 1'b0;
        hold_req  = 1'b0;
        chk("sh_valid",  16'(spawn_valid), 16'd1);
        chk("sh_idx",    16'(spawn_idx), 16'(p[2:0]));
        chk("sh_fromh",  16'(spawn_from_hold), 16'd0);
        chk("sh_reject", 16'(hold_reject), 16'd1);
        chk("sh_hold",   16'(hold_idx), 16'd6);
        chk("sh_dealt",  pieces_dealt, 16'd9);

        // Back-to-back spawns: 21 pulses, three complete bags
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        seen      = 7'h00;
        spawn_req = 1'b1;
        for (int k = 0; k < 21; k++) begin
            tick();
            chk("burst_valid", 16'(spawn_valid), 16'd1);
            chk("burst_prev_full", 16'(no_empty(preview)), 16'd1);
            seen = seen | (7'b1 << spawn_idx);
            if ((k % 7) == 6) begin
                chk("burst_bag", 16'(seen), 16'h007F);
                seen = 7'h00;
            end
        end
        spawn_req = 1'b0;
        chk("burst_dealt", pieces_dealt, 16'd21);
        tick();
        chk("burst_end", 16'(spawn_valid), 16'd0);

        // Reset in the middle of a burst
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        spawn_req = 1'b1;
        for (int k = 0; k < 10; k++) tick();
        chk("mid_dealt_pre", pieces_dealt, 16'd10);
        rst = 1'b1;
        tick();
        check_reset_state("midrst");
        rst       = 1'b0;
        spawn_req = 1'b0;
        tick();
        chk("midrst_nopend", 16'(spawn_valid), 16'd0);
        chk("midrst_first",  16'(preview), 16'({3'd7, 3'd7, 3'd1}));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/piece_queue.md
# piece_queue

Parametrised next-piece source for the Tetris datapath: a 7-bag (or uniform-random) tetromino generator feeding a PREVIEW_DEPTH-deep preview FIFO, plus the hold slot with per-piece hold lockout. It replaces the single-entry next/hold registers inside `game_control`. `game_control` issues spawn and hold requests and receives the piece index to place; the renderer reads the preview and hold outputs directly.

## Interface
- PREVIEW_DEPTH, 3: preview entries shown and buffered (1..6).
- RANDOM_MODE, 0: 0 = 7-bag, 1 = uniform random (no bag).
- LFSR_SEED, 16'hACE1: LFSR reset value; 0 is replaced by 16'h0001.
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- spawn_req  in  1  one-cycle pulse: deliver next queued piece.
- hold_req  in  1  one-cycle pulse: hold the current piece.
- cur_idx  in  3  index of the piece in play, sampled with hold_req.
- lock_done  in  1  one-cycle pulse: current piece locked; clears lockout.
- spawn_valid  out  1  one-cycle pulse: spawn_idx is valid.
- spawn_idx  out  3  piece to place.
- spawn_from_hold  out  1  qualifies spawn_valid: piece came from the hold slot.
- hold_reject  out  1  one-cycle pulse: hold_req ignored.
- preview_idx  out  PREVIEW_DEPTH×3  entry 0 = next piece.
- hold_idx  out  3  hold slot contents.
- hold_used  out  1  hold lockout flag.
- pieces_dealt  out  16  pieces taken from the queue, saturating.

## Operation
- Encoding: 0..6 = I,O,T,S,Z,J,L. `TETROMINO_EMPTY` = 3'd7.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Advances every cycle out of reset.
- Candidate: c = lfsr[2:0], with 7 mapped to 0.
- Bag mode: the pushed piece is the first set bit of bag_mask scanning upward from c, with wrap. That bit is cleared. When the last bit clears, bag_mask reloads 7'h7F on the same edge.
- Random mode: push c directly. bag_mask is unused.
- Refill: one push per cycle while count < PREVIEW_DEPTH. A simultaneous pop and push is allowed: entries shift down and the new piece lands at index count-1.
- Spawn: spawn_req with count > 0 pops entry 0 to spawn_idx. Then spawn_valid=1, spawn_from_hold=0, and pieces_dealt increments (saturating at 16'hFFFF).
- Spawn with count = 0: the request is latched as pending. It is serviced on the first cycle count > 0. A second spawn_req while pending is absorbed.
- Hold with hold_used=1: hold_reject pulses. No other state changes.
- Hold with an empty slot: hold_idx ← cur_idx, then the queue is popped exactly as for spawn (spawn_from_hold=0). hold_used ← 1.
- Hold with a full slot: spawn_idx ← hold_idx, hold_idx ← cur_idx, spawn_from_hold=1, hold_used ← 1. The queue is not popped.
- Hold needing a pop while count = 0: treated like pending spawn, with the hold_idx write done immediately.
- Simultaneous spawn_req and hold_req: spawn wins. hold_reject pulses.
- Simultaneous lock_done and hold_req: the hold is evaluated against the pre-clear hold_used. lock_done clears the flag on the same edge unless the hold is accepted; an accepted hold leaves hold_used=1.
- Outputs after reset:
  - preview_idx all EMPTY, hold_idx EMPTY, spawn_idx EMPTY.
  - spawn_valid, spawn_from_hold, hold_reject, hold_used all 0.
  - pieces_dealt 0, count 0, bag_mask 7'h7F, pending 0, lfsr = seed.

## Timing
- All outputs are registered.
- Request sampled at edge N → spawn_valid / hold_reject high for the cycle after N only.
- preview_idx reflects the pop at edge N.
- After rst deasserts, the preview is full after PREVIEW_DEPTH cycles.
- Pending spawn: spawn_valid is asserted the cycle after the first push.
- Steady state: sustains one spawn per cycle with no stall once full.
- rst mid-operation: reset values on the next edge. Pending requests and the partial bag are discarded.

## Structure
- Add to GLOBAL.sv:
  - `TETROMINO_EMPTY` (already there).
  - `PIECE_KINDS` = 7.
  - typedef piece_idx_t (logic [2:0]).
- One sub-module, `bag_picker`: combinational first-set-bit scan from c with wrap. Inputs bag_mask and c; outputs the chosen index and the next mask. Everything else (FIFO, hold, LFSR, counters) lives in piece_queue.

## Test plan
- Reset, wait 5 cycles, then 7 spawn_req pulses 2 cycles apart (RANDOM_MODE=0) → spawn_idx values are a permutation of 0..6. preview_idx never contains EMPTY after cycle PREVIEW_DEPTH.
- hold_req with cur_idx=3 and an empty slot → hold_idx=3, spawn_valid with the former preview_idx[0], spawn_from_hold=0, hold_used=1, pieces_dealt+1.
- A second hold_req before lock_done → hold_reject=1 for one cycle, no spawn_valid, hold_idx stays 3.
- lock_done, then hold_req with cur_idx=5 → spawn_idx=3, spawn_from_hold=1, hold_idx=5, preview unchanged.
- spawn_req on the first cycle after reset → pending. spawn_valid two cycles after reset release, with the first pushed piece.
- spawn_req every cycle for 21 cycles after fill → 21 consecutive spawn_valid pulses, three complete bags, pieces_dealt=21. Assert rst at cycle 10 → all reset values on the next cycle.
